// File: rtl/fb_pkg.sv
// fb_pkg: screen geometry, plot command and state types, address helper
package fb_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int FB_PIXELS = 76800;
  localparam int FB_ADDR_W = 17;
  localparam int COLOUR_W = 3;
  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [COLOUR_W-1:0] colour;
  } plot_cmd_t;
  typedef enum logic {S_IDLE, S_CLEAR} fb_state_t;
  // y*320+x as y*256+y*64+x, no multiplier
  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
    return {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};
  endfunction
endpackage

// File: rtl/fb_plot_writer_if.sv
// fb_plot_writer_if: plot strobe bus and framebuffer write handshake
interface fb_plot_writer_if #(parameter int COLOUR_W = 3);
  logic plot;
  logic [8:0] plot_x;
  logic [7:0] plot_y;
  logic [COLOUR_W-1:0] plot_colour;
  logic mem_grant;
  logic mem_we;
  logic [16:0] mem_addr;
  logic [COLOUR_W-1:0] mem_wdata;
  modport slave (input plot, plot_x, plot_y, plot_colour, mem_grant, output mem_we, mem_addr, mem_wdata);
  modport master (output plot, plot_x, plot_y, plot_colour, mem_grant, input mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/plot_fifo.sv
// plot_fifo: synchronous FIFO with wrap-around pointers carrying an extra MSB
module plot_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter type T = plot_cmd_t
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
  assign dout = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
endmodule

// File: rtl/fb_plot_writer.sv
// fb_plot_writer: buffers pixel plots, converts to linear addresses and writes them,
// plus full-screen clear; FIFO drain pauses while a clear is filling.
module fb_plot_writer
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int COLOUR_W = fb_pkg::COLOUR_W
) (
  input  logic                clk,
  input  logic                rstn,
  fb_plot_writer_if.slave     bus,
  input  logic                clear,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                busy,
  output logic                clear_done,
  output logic                overflow,
  output logic [15:0]         drop_count
);
  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [COLOUR_W-1:0] colour;
  } cmd_t;
  fb_state_t state, state_d;
  logic [FB_ADDR_W-1:0] cnt;
  logic [COLOUR_W-1:0] clr_colour;
  logic is_clr, full, empty, in_range, done, free, pop, push, load_clr, last, start;
  cmd_t head, cmd_in;
  assign cmd_in = '{x: bus.plot_x, y: bus.plot_y, colour: bus.plot_colour};
  assign in_range = bus.plot_x < 9'(SCREEN_W) && bus.plot_y < 8'(SCREEN_H);
  assign done = bus.mem_we && bus.mem_grant;
  assign free = !bus.mem_we || done;
  assign pop = state == S_IDLE && !empty && free;
  assign push = bus.plot && in_range && (!full || pop);
  assign load_clr = state == S_CLEAR && cnt != FB_ADDR_W'(FB_PIXELS) && free;
  assign last = done && is_clr && bus.mem_addr == FB_ADDR_W'(FB_PIXELS - 1);
  assign start = state == S_IDLE && clear;
  assign busy = state == S_CLEAR || !empty || bus.mem_we;
  plot_fifo #(.DEPTH(FIFO_DEPTH), .T(cmd_t)) u_fifo (
    .clk, .rstn, .push, .pop, .din(cmd_in), .dout(head), .full, .empty
  );
  always_comb begin
    state_d = state;
    state_d = start ? S_CLEAR : last ? S_IDLE : state;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= S_IDLE;
    else state <= state_d;
  // cnt counts fill pixels issued to the output register; is_clr marks a fill write in flight
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      clr_colour <= '0;
      is_clr <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      clear_done <= 1'b0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      clear_done <= last;
      if (start) begin
        cnt <= '0;
        clr_colour <= clear_colour;
      end else if (load_clr) cnt <= cnt + 1'b1;
      if (pop) begin
        bus.mem_we <= 1'b1;
        bus.mem_addr <= pix_addr(head.x, head.y);
        bus.mem_wdata <= head.colour;
        is_clr <= 1'b0;
      end else if (load_clr) begin
        bus.mem_we <= 1'b1;
        bus.mem_addr <= cnt;
        bus.mem_wdata <= clr_colour;
        is_clr <= 1'b1;
      end else if (done) begin
        bus.mem_we <= 1'b0;
        is_clr <= 1'b0;
      end
      if (bus.plot && in_range && !push) overflow <= 1'b1;
      else if (start) overflow <= 1'b0;
      if (bus.plot && !in_range && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
endmodule

// File: tb/tb_fb_plot_writer.sv
// tb_fb_plot_writer: directed and randomized checks against a write-list reference model
module tb_fb_plot_writer;
  logic clk = 0, rstn = 0, clear = 0;
  logic [2:0] clear_colour = 0;
  logic busy, clear_done, overflow;
  logic [15:0] drop_count;
  fb_plot_writer_if #(.COLOUR_W(3)) bus();
  fb_plot_writer #(.FIFO_DEPTH(16), .COLOUR_W(3)) dut (
    .clk, .rstn, .bus(bus), .clear, .clear_colour, .busy, .clear_done, .overflow, .drop_count
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic [19:0] got[$];
  int done_cnt = 0, done_at = -1;
  always @(negedge clk)
    if (rstn) begin
      if (bus.mem_we && bus.mem_grant) got.push_back({bus.mem_addr, bus.mem_wdata});
      if (clear_done) begin
        done_cnt++;
        done_at = got.size();
      end
    end
  function automatic logic [19:0] wr(input int x, input int y, input int c);
    logic [16:0] a;
    logic [2:0] d;
    a = 17'(y * 320 + x);
    d = 3'(c);
    return {a, d};
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rstn = 0;
    bus.plot = 0; bus.plot_x = 0; bus.plot_y = 0; bus.plot_colour = 0; bus.mem_grant = 0;
    clear = 0; clear_colour = 0;
    tick(2);
    rstn = 1;
    got.delete();
    done_cnt = 0;
    done_at = -1;
    tick(1);
  endtask
  task automatic send(input int x, input int y, input int c);
    bus.plot = 1; bus.plot_x = 9'(x); bus.plot_y = 8'(y); bus.plot_colour = 3'(c);
    tick(1);
    bus.plot = 0;
  endtask
  task automatic test_reset();
    do_reset();
    rstn = 0;
    tick(1);
    tests++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, clear_done, overflow, drop_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got we=%b addr=%0d wd=%0d busy=%b cd=%b ov=%b drops=%0d, want all 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, clear_done, overflow, drop_count);
    end
    rstn = 1;
    tick(1);
  endtask
  task automatic test_single();
    do_reset();
    bus.mem_grant = 1;
    send(5, 2, 3);
    tests++;
    if (bus.mem_we !== 1'b0) begin
      fails++;
      $display("FAIL single_latency_e1: we=%b want 0", bus.mem_we);
    end
    tick(1);
    tests++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 17'd645, 3'd3}) begin
      fails++;
      $display("FAIL single_write: we=%b addr=%0d wd=%0d want 1/645/3", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick(5);
    tests++;
    if (got.size() != 1 || got[0] !== wr(5, 2, 3)) begin
      fails++;
      $display("FAIL single_count: writes=%0d want 1 at 645/3", got.size());
    end
  endtask
  task automatic test_range();
    do_reset();
    bus.mem_grant = 1;
    send(319, 239, 7);
    send(320, 0, 1);
    send(0, 240, 2);
    tick(6);
    tests++;
    if (got.size() != 1 || got[0] !== wr(319, 239, 7)) begin
      fails++;
      $display("FAIL range_writes: writes=%0d first=%h want 1 write %h", got.size(), got.size() ? got[0] : 20'h0, wr(319, 239, 7));
    end
    tests++;
    if (drop_count !== 16'd2 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL range_status: drops=%0d ov=%b want 2/0", drop_count, overflow);
    end
  endtask
  task automatic test_overflow();
    int bad = 0;
    do_reset();
    bus.mem_grant = 0;
    for (int i = 0; i < 18; i++) send(i, 0, i % 8);
    tick(2);
    tests++;
    if (overflow !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 17'd0) begin
      fails++;
      $display("FAIL overflow_hold: ov=%b we=%b addr=%0d want 1/1/0", overflow, bus.mem_we, bus.mem_addr);
    end
    bus.mem_grant = 1;
    tick(30);
    for (int i = 0; i < 17 && i < got.size(); i++) if (got[i] !== wr(i, 0, i % 8)) bad++;
    tests++;
    if (got.size() != 17 || bad != 0) begin
      fails++;
      $display("FAIL overflow_drain: writes=%0d out_of_order=%0d want 17/0", got.size(), bad);
    end
  endtask
  task automatic test_clear();
    int n = 0, bad = 0;
    logic [19:0] tail[3];
    tail[0] = wr(10, 1, 4); tail[1] = wr(300, 200, 1); tail[2] = wr(0, 0, 7);
    do_reset();
    bus.mem_grant = 1;
    clear = 1; clear_colour = 2;
    tick(1);
    clear = 0; clear_colour = 5;
    tick(100);
    send(10, 1, 4);
    send(300, 200, 1);
    tick(3);
    send(0, 0, 7);
    while (done_cnt == 0 && n < 80000) begin
      tick(1);
      n++;
    end
    tests++;
    if (done_cnt == 0) begin
      fails++;
      $display("FAIL clear_timeout: clear_done never seen after %0d cycles, writes=%0d", n, got.size());
    end
    tick(10);
    for (int i = 0; i < 76800 && i < got.size(); i++) if (got[i] !== wr(i % 320, i / 320, 2)) bad++;
    tests++;
    if (got.size() != 76803 || bad != 0) begin
      fails++;
      $display("FAIL clear_fill: writes=%0d bad=%0d want 76803/0", got.size(), bad);
    end
    tests++;
    if (done_cnt != 1 || done_at != 76800) begin
      fails++;
      $display("FAIL clear_done_pulse: pulses=%0d at_write=%0d want 1 at 76800", done_cnt, done_at);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) if (76800 + i >= got.size() || got[76800+i] !== tail[i]) bad++;
    tests++;
    if (bad != 0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL clear_tail_plots: bad=%0d ov=%b want 0/0", bad, overflow);
    end
  endtask
  task automatic test_reset_mid_clear();
    int n = 0;
    do_reset();
    bus.mem_grant = 1;
    clear = 1; clear_colour = 6;
    tick(1);
    clear = 0;
    while (!(bus.mem_we && bus.mem_addr == 17'd1000) && n < 2000) begin
      tick(1);
      n++;
    end
    tests++;
    if (!(bus.mem_we && bus.mem_addr == 17'd1000)) begin
      fails++;
      $display("FAIL midclear_reach: addr=%0d we=%b want 1000/1", bus.mem_addr, bus.mem_we);
    end
    #2 rstn = 0;
    #1;
    tests++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, clear_done, overflow, drop_count} !== '0) begin
      fails++;
      $display("FAIL midclear_async: we=%b addr=%0d busy=%b want all 0", bus.mem_we, bus.mem_addr, busy);
    end
    tick(2);
    rstn = 1;
    got.delete();
    tick(20);
    tests++;
    if (got.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midclear_quiet: writes=%0d busy=%b want 0/0", got.size(), busy);
    end
  endtask
  task automatic test_random();
    logic [19:0] exp[$];
    int drops = 0, sent = 0, n = 0, bad = 0, x, y, c;
    do_reset();
    while (sent < 2000) begin
      bus.mem_grant = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 35) begin
        x = $urandom_range(0, 339); y = $urandom_range(0, 249); c = $urandom_range(0, 7);
        bus.plot = 1; bus.plot_x = 9'(x); bus.plot_y = 8'(y); bus.plot_colour = 3'(c);
        if (x < 320 && y < 240) exp.push_back(wr(x, y, c));
        else drops++;
        sent++;
      end else bus.plot = 0;
      tick(1);
    end
    bus.plot = 0;
    bus.mem_grant = 1;
    while (busy && n < 500) begin
      tick(1);
      n++;
    end
    tick(2);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL random_drain: busy=%b after %0d cycles", busy, n);
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) if (got[i] !== exp[i]) bad++;
    tests++;
    if (got.size() != exp.size() || bad != 0) begin
      fails++;
      $display("FAIL random_scoreboard: writes=%0d want %0d, mismatched=%0d", got.size(), exp.size(), bad);
    end
    tests++;
    if (overflow !== 1'b0 || drop_count !== 16'(drops)) begin
      fails++;
      $display("FAIL random_status: ov=%b drops=%0d want 0/%0d", overflow, drop_count, drops);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_range();
    test_overflow();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
